// File: rtl/mult_appx_pkg.sv
// mult_appx_pkg: shared definitions for the approximate/exact multiplier selector.
//   mode_e      - per-sample output selection mode (2-bit encoding used on the mode port)
//   fsm_state_e - adaptive error-budget state machine states
//   sat_add     - saturating adder used by the error accumulators
package mult_appx_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_APPX  = 2'd1,
    MODE_MAX   = 2'd2,
    MODE_ADAPT = 2'd3
  } mode_e;

  typedef enum logic {
    ST_APPX  = 1'b0,
    ST_EXACT = 1'b1
  } fsm_state_e;

  // Working width for sat_add; callers zero-extend into it and truncate the
  // result back to their accumulator width (the result never exceeds max_val).
  localparam int SAT_W = 128;

  // Returns acc + inc, clipped to max_val.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input logic [SAT_W-1:0] max_val);
    logic [SAT_W:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    else                       return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/mult_appx_trunc.sv
// mult_appx_trunc: combinational truncation-based approximate multiplier.
// The TRUNC least-significant bits of each operand are cleared before an
// exact unsigned multiply, so the result never exceeds the exact product.
//   a, b  in  W    unsigned operands
//   p_ap  out 2*W  approximate product
module mult_appx_trunc #(
  parameter int W     = 32,
  parameter int TRUNC = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p_ap
);

  localparam int PW = 2 * W;
  localparam logic [W-1:0] MASK = {W{1'b1}} << TRUNC;

  assign p_ap = PW'(a & MASK) * PW'(b & MASK);

endmodule

// File: rtl/mult_appx_sel_pipe.sv
// mult_appx_sel_pipe: valid-qualified 3-register pipeline that multiplies each
// operand pair exactly and approximately, then selects one product per sample.
// Outputs update on the second rising edge after the edge that captures aa/bb.
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand pair present
//   aa, bb     in   W      unsigned operands
//   mode       in   2      0 exact, 1 approx, 2 max, 3 adaptive
//   out_valid  out  1      yy_out valid
//   yy_out     out  2W     selected product
//   out_appx   out  1      yy_out is the approximate product and differs from exact
//   err_win    out  ACC_W  saturating error sum of the current adaptive window
//   err_total  out  ACC_W  saturating error sum over every accepted sample
//   fallback   out  1      adaptive FSM is in EXACT
module mult_appx_sel_pipe
  import mult_appx_pkg::*;
#(
  parameter int W       = 32,
  parameter int TRUNC   = 8,
  parameter int WIN     = 16,
  parameter int ERR_THR = 1024,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     aa,
  input  logic [W-1:0]     bb,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [2*W-1:0]   yy_out,
  output logic             out_appx,
  output logic [ACC_W-1:0] err_win,
  output logic [ACC_W-1:0] err_total,
  output logic             fallback
);

  localparam int PW    = 2 * W;
  localparam int CNT_W = $clog2(WIN + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] THR     = ACC_W'(ERR_THR);
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(WIN);

  // ---------------- S0: input register ----------------
  logic         v0;
  logic [W-1:0] a0, b0;
  logic [1:0]   m0;

  // NOTE: every pipeline register is reset, not just the valid bits, because
  // the block must present all-zero state after reset, not merely invalid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
      m0 <= '0;
    end else begin
      // NOTE: state is written with non-blocking assignments so every register
      // samples the pre-edge values of the others, regardless of block order.
      v0 <= in_valid;
      if (in_valid) begin
        a0 <= aa;
        b0 <= bb;
        m0 <= mode;
      end
    end
  end

  // ---------------- S1: compute ----------------
  logic [PW-1:0] p_ex, p_ap, err;

  mult_appx_trunc #(.W(W), .TRUNC(TRUNC)) u_trunc (
    .a    (a0),
    .b    (b0),
    .p_ap (p_ap)
  );

  assign p_ex = PW'(a0) * PW'(b0);
  // Clearing operand bits can only shrink the product, so this never underflows.
  assign err  = p_ex - p_ap;

  logic          v1;
  logic [PW-1:0] pex1, pap1, err1;
  logic [1:0]    m1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      pex1 <= '0;
      pap1 <= '0;
      err1 <= '0;
      m1   <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        pex1 <= p_ex;
        pap1 <= p_ap;
        err1 <= err;
        m1   <= m0;
      end
    end
  end

  // ---------------- S2: select, adaptive FSM, statistics ----------------
  fsm_state_e       state, state_n;
  logic [CNT_W-1:0] win_cnt, cnt_n, cnt_inc;
  logic [ACC_W-1:0] win_n, win_sum, tot_sum;
  logic             sel_ap;
  logic             adapt_smp;

  assign adapt_smp = v1 && (m1 == MODE_ADAPT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_APPX;
    else     state <= state_n;
  end

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    win_n   = err_win;
    cnt_n   = win_cnt;
    cnt_inc = win_cnt + CNT_W'(1);
    win_sum = ACC_W'(sat_add(SAT_W'(err_win), SAT_W'(err1), SAT_W'(ACC_MAX)));
    tot_sum = ACC_W'(sat_add(SAT_W'(err_total), SAT_W'(err1), SAT_W'(ACC_MAX)));
    sel_ap  = 1'b0;

    // Selection uses the FSM state before this sample's own update.
    case (mode_e'(m1))
      MODE_EXACT: sel_ap = 1'b0;
      MODE_APPX:  sel_ap = 1'b1;
      MODE_MAX:   sel_ap = (pap1 > pex1);
      MODE_ADAPT: sel_ap = (state == ST_APPX);
      default:    sel_ap = 1'b0;
    endcase

    if (adapt_smp) begin
      if (cnt_inc == WIN_END) begin
        // Window closes: budget restarts and approximation is re-enabled,
        // even if this very sample would have crossed the threshold.
        win_n   = '0;
        cnt_n   = '0;
        state_n = ST_APPX;
      end else begin
        win_n = win_sum;
        cnt_n = cnt_inc;
        if ((state == ST_APPX) && (win_sum > THR)) state_n = ST_EXACT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      yy_out    <= '0;
      out_appx  <= 1'b0;
      err_win   <= '0;
      err_total <= '0;
      win_cnt   <= '0;
    end else begin
      out_valid <= v1;
      err_win   <= win_n;
      win_cnt   <= cnt_n;
      if (v1) begin
        yy_out    <= sel_ap ? pap1 : pex1;
        out_appx  <= sel_ap && (pap1 != pex1);
        err_total <= tot_sum;
      end
    end
  end

  assign fallback = (state == ST_EXACT);

endmodule

// File: tb/tb_mult_appx_sel_pipe.sv
// tb_mult_appx_sel_pipe: directed and randomized self-checking bench for
// mult_appx_sel_pipe (W=8, TRUNC=2, WIN=4, ERR_THR=20, ACC_W=16), plus a second
// instance with ACC_W=6 sharing the same stimulus for accumulator saturation.
module tb_mult_appx_sel_pipe;

  localparam int W       = 8;
  localparam int TRUNC   = 2;
  localparam int WIN     = 4;
  localparam int ERR_THR = 20;
  localparam int ACC_W   = 16;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     aa, bb;
  logic [1:0]       mode;
  logic             out_valid, out_appx, fallback;
  logic [2*W-1:0]   yy_out;
  logic [ACC_W-1:0] err_win, err_total;

  logic             s_out_valid, s_out_appx, s_fallback;
  logic [2*W-1:0]   s_yy_out;
  logic [5:0]       s_err_win, s_err_total;

  always #5 clk = ~clk;

  mult_appx_sel_pipe #(.W(W), .TRUNC(TRUNC), .WIN(WIN), .ERR_THR(ERR_THR), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aa(aa), .bb(bb), .mode(mode),
    .out_valid(out_valid), .yy_out(yy_out), .out_appx(out_appx),
    .err_win(err_win), .err_total(err_total), .fallback(fallback)
  );

  mult_appx_sel_pipe #(.W(W), .TRUNC(TRUNC), .WIN(WIN), .ERR_THR(ERR_THR), .ACC_W(6)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aa(aa), .bb(bb), .mode(mode),
    .out_valid(s_out_valid), .yy_out(s_yy_out), .out_appx(s_out_appx),
    .err_win(s_err_win), .err_total(s_err_total), .fallback(s_fallback)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit              v;
    longint unsigned yy;
    bit              appx;
    longint unsigned win;
    longint unsigned tot;
    bit              fb;
  } exp_t;

  longint unsigned m_tot, m_win;
  int              m_cnt;
  bit              m_fb;
  exp_t            pipe0, pipe1, exp_cur;

  function automatic longint unsigned sat(input longint unsigned x);
    return (x > ACC_MAX) ? ACC_MAX : x;
  endfunction

  // Processes one accepted sample in arrival order and returns what the
  // output must show for it.
  function exp_t model_step(input int a, input int b, input int m);
    exp_t e;
    longint unsigned pex, pap, err;
    bit use_ap;
    int at, bt;
    at  = (a / (1 << TRUNC)) * (1 << TRUNC);
    bt  = (b / (1 << TRUNC)) * (1 << TRUNC);
    pex = longint'(a) * longint'(b);
    pap = longint'(at) * longint'(bt);
    err = pex - pap;
    m_tot = sat(m_tot + err);
    use_ap = 1'b0;
    if (m == 0)      use_ap = 1'b0;
    else if (m == 1) use_ap = 1'b1;
    else if (m == 2) use_ap = (pap > pex);
    else begin
      use_ap = !m_fb;
      m_cnt++;
      m_win = sat(m_win + err);
      if (m_cnt == WIN) begin
        m_cnt = 0;
        m_win = 0;
        m_fb  = 1'b0;
      end else if (!m_fb && m_win > ERR_THR) begin
        m_fb = 1'b1;
      end
    end
    e.v    = 1'b1;
    e.yy   = use_ap ? pap : pex;
    e.appx = use_ap && (pap != pex);
    e.win  = m_win;
    e.tot  = m_tot;
    e.fb   = m_fb;
    return e;
  endfunction

  // Two-sample delay line between capture and output.
  always @(posedge clk) begin
    if (rst) begin
      pipe0.v = 1'b0;
      pipe1.v = 1'b0;
      exp_cur.v = 1'b0;
      m_tot = 0; m_win = 0; m_cnt = 0; m_fb = 1'b0;
    end else begin
      exp_cur = pipe1;
      pipe1   = pipe0;
      if (in_valid) pipe0 = model_step(int'(aa), int'(bb), int'(mode));
      else          pipe0.v = 1'b0;
    end
  end

  // ---------------- compare process + output log ----------------
  bit              checking = 1'b0;
  int              log_n = 0;
  longint unsigned log_yy[16], log_win[16], log_tot[16];
  bit              log_appx[16], log_fb[16];

  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 64'(out_valid), 64'(exp_cur.v));
      if (exp_cur.v) begin
        check("yy_out",    64'(yy_out),    exp_cur.yy);
        check("out_appx",  64'(out_appx),  64'(exp_cur.appx));
        check("err_win",   64'(err_win),   exp_cur.win);
        check("err_total", 64'(err_total), exp_cur.tot);
        check("fallback",  64'(fallback),  64'(exp_cur.fb));
      end
      if (out_valid && log_n < 16) begin
        log_yy[log_n]   = 64'(yy_out);
        log_win[log_n]  = 64'(err_win);
        log_tot[log_n]  = 64'(err_total);
        log_appx[log_n] = out_appx;
        log_fb[log_n]   = fallback;
        log_n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int a, input int b, input int m);
    in_valid = 1'b1;
    aa   = W'(a);
    bb   = W'(b);
    mode = 2'(m);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 0);
    check({tag, " yy_out"},    64'(yy_out),    0);
    check({tag, " out_appx"},  64'(out_appx),  0);
    check({tag, " err_win"},   64'(err_win),   0);
    check({tag, " err_total"}, 64'(err_total), 0);
    check({tag, " fallback"},  64'(fallback),  0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; aa = '0; bb = '0; mode = '0;
    repeat (2) @(negedge clk);
    check_zero_state("reset");
    check("reset sat err_total", 64'(s_err_total), 0);
    rst = 1'b0;
    checking = 1'b1;

    // Fixed modes followed by one adaptive window and the start of the next.
    log_n = 0;
    send(15, 3, 0);
    send(7, 7, 1);
    send(15, 3, 2);
    repeat (5) send(7, 7, 3);
    idle(4);
    check("A count", 64'(log_n), 8);
    check("A0 yy", log_yy[0], 45);  check("A0 appx", 64'(log_appx[0]), 0); check("A0 tot", log_tot[0], 45);
    check("A1 yy", log_yy[1], 16);  check("A1 appx", 64'(log_appx[1]), 1); check("A1 tot", log_tot[1], 78);
    check("A2 yy", log_yy[2], 45);  check("A2 appx", 64'(log_appx[2]), 0); check("A2 tot", log_tot[2], 123);
    check("A3 yy", log_yy[3], 16);  check("A3 fb", 64'(log_fb[3]), 1);     check("A3 win", log_win[3], 33);
    check("A4 yy", log_yy[4], 49);  check("A4 win", log_win[4], 66);
    check("A5 yy", log_yy[5], 49);  check("A5 win", log_win[5], 99);
    check("A6 yy", log_yy[6], 49);  check("A6 fb", 64'(log_fb[6]), 0);     check("A6 win", log_win[6], 0);
    check("A7 yy", log_yy[7], 16);  check("A7 fb", 64'(log_fb[7]), 1);

    // Threshold crossing on the window-closing sample is overridden.
    do_reset();
    log_n = 0;
    repeat (3) send(4, 4, 3);
    send(7, 7, 3);
    idle(4);
    check("B count", 64'(log_n), 4);
    check("B0 yy", log_yy[0], 16);
    check("B2 yy", log_yy[2], 16);  check("B2 win", log_win[2], 0);
    check("B3 yy", log_yy[3], 16);  check("B3 appx", 64'(log_appx[3]), 1);
    check("B3 fb", 64'(log_fb[3]), 0); check("B3 win", log_win[3], 0);

    // Reset while two samples are in flight: nothing stale may emerge.
    send(9, 9, 0);
    send(10, 10, 1);
    do_reset();
    check_zero_state("midreset");
    log_n = 0;
    idle(3);
    check("midreset stale outputs", 64'(log_n), 0);

    // Saturation of the 6-bit accumulator: 33 + 33 clips to 63.
    send(7, 7, 1);
    send(7, 7, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("sat first err_total", 64'(s_err_total), 33);
    @(negedge clk);
    check("sat second err_total", 64'(s_err_total), 63);
    check("nosat second err_total", 64'(err_total), 66);

    // Randomized traffic with occasional mid-stream resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        aa = W'($urandom_range(0, 15));
        bb = W'($urandom_range(0, 15));
      end else begin
        aa = W'($urandom_range(0, 255));
        bb = W'($urandom_range(0, 255));
      end
      r    = $urandom_range(0, 7);
      mode = (r > 3) ? 2'd3 : 2'(r);
      @(negedge clk);
    end
    rst = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_appx_sel_pipe.md
Name: mult_appx_sel_pipe

Overview:
- Parametrised, valid-qualified successor to the registered approximate/exact multiplier selector.
- Each operand pair is multiplied by an exact unsigned multiplier and a truncation-based approximate multiplier in parallel.
- The output is chosen per sample by a mode: exact, approximate, max-of-both, or adaptive.
- In adaptive mode a windowed error-budget state machine falls back to exact results once the window's accumulated error exceeds a threshold.
- Sits between the operand source and the datapath accumulator in the approximate-computing functional-unit set.

Parameters:
- W, 32, operand width (unsigned); product width is 2*W.
- TRUNC, 8, operand LSBs zeroed by the approximate multiplier; legal range 0..W-1.
- WIN, 16, window length in accepted samples for adaptive mode; legal range >= 1.
- ERR_THR, 1024, error budget per window; exceeding it (strictly greater) forces exact.
- ACC_W, 40, width of the saturating error accumulators.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair present this cycle.
- aa  in  W  operand A.
- bb  in  W  operand B.
- mode  in  2  0 exact, 1 approx, 2 max, 3 adaptive; sampled together with aa/bb.
- out_valid  out  1  yy_out is valid.
- yy_out  out  2W  selected product.
- out_appx  out  1  1 when yy_out is the approximate product.
- err_win  out  ACC_W  saturating error sum for the current adaptive window.
- err_total  out  ACC_W  saturating error sum over all accepted samples, in every mode.
- fallback  out  1  adaptive FSM is in the EXACT state.

Behaviour:
- Reset: all outputs and all pipeline registers are 0; the FSM is in APPX; the window counter is 0. Reset mid-stream drops in-flight samples; out_valid is 0 in the cycle after rst is sampled high.
- S0, input register: when in_valid=1, capture aa, bb, mode and set v0=1; otherwise v0=0. No backpressure; one sample per cycle.
- S1, compute: p_ex = a*b; p_ap = (a with low TRUNC bits cleared) * (b likewise); err = p_ex - p_ap, which is always >= 0. Register p_ex, p_ap, err, mode, v1.
- S2, select, output register:
  - mode 0 selects p_ex; mode 1 selects p_ap; mode 2 selects max(p_ex, p_ap).
  - mode 3 selects p_ap if the FSM is APPX before this sample's update, else p_ex.
  - out_appx = 1 exactly when p_ap was selected and p_ap != p_ex. In mode 2 this is always 0.
- Latency: 2 cycles from in_valid/aa/bb to out_valid/yy_out; throughput 1 per cycle.
- err_total accumulates err on every valid S1 sample and saturates at 2^ACC_W-1 (it never wraps).
- Adaptive FSM advances only on valid S1 samples with mode=3; other modes leave the FSM, err_win and the window counter unchanged.
- FSM states:
  - APPX: add err to err_win (saturating). If the new err_win > ERR_THR, go to EXACT.
  - EXACT: add err to err_win (saturating); stay in EXACT.
- Window counter increments on every adaptive sample. On the sample that makes the count reach WIN:
  - err_win and the counter clear to 0;
  - the FSM goes to APPX, overriding any threshold crossing on that sample;
  - the sample itself is still selected using the pre-update state.
- err_win and fallback reflect the registered post-update values, visible in the same cycle as that sample's yy_out.
- Simultaneous reset and valid: reset wins.

Decomposition:
- Package mult_appx_pkg holds the mode encodings (MODE_EXACT, MODE_APPX, MODE_MAX, MODE_ADAPT), the FSM state enum (ST_APPX, ST_EXACT), and a sat_add function.
- One sub-module, mult_appx_trunc (parameters W, TRUNC; combinational), produces p_ap.
- The exact product is written inline.

Test Plan (W=8, TRUNC=2, WIN=4, ERR_THR=20, ACC_W=16):
- mode0, aa=15, bb=3 -> two cycles later yy_out=45, out_appx=0, err_total=45.
- mode1, aa=7, bb=7 -> yy_out=16 (4*4), out_appx=1, err_total += 33.
- mode2, aa=15, bb=3 -> yy_out=45 (max of 45 and 0), out_appx=0.
- mode3, four back-to-back (7,7) samples:
  - first: yy_out=16, fallback=1, err_win=33;
  - second and third: 49, 49;
  - fourth: 49, with err_win=0 and fallback=0 after it.
  - A fifth sample returns 16.
- mode3, (4,4) x3 (err 0) then (7,7) -> outputs 16, 16, 16, 16; the window closes, so fallback stays 0.
- Assert rst for one cycle while 2 samples are in flight -> out_valid=0 and all stats are 0 on the next cycle; no stale yy_out appears.
- Saturation: ACC_W=6, mode1, (7,7) x2 -> err_total=63, not 66 mod 64.
